// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - micro-cycle control sequencer for the 8-bit CPU
// Optional feature macro: CPU_CTRL_ILLEGAL_TRAP_EN (undefined opcodes park in HALT)

module cpu_ctrl_seq #(
  parameter int INST_W    = 8,
  parameter int CYCLE_W   = 4,
  parameter int MAX_CYCLE = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INST_W-1:0]  instruction,
  input  logic               stall,
  input  logic               run,
  output logic [7:0]         state,
  output logic [CYCLE_W-1:0] cycle,
  output logic [7:0]         opcode,
  output logic               inst_done,
  output logic               halted,
  output logic               illegal
);

  if (INST_W < 8) begin : g_bad_inst_w
    $error("cpu_ctrl_seq: INST_W must be at least 8");
  end
  if (MAX_CYCLE < 6 || MAX_CYCLE > (1 << CYCLE_W) - 1) begin : g_bad_max_cycle
    $error("cpu_ctrl_seq: MAX_CYCLE must lie in 6 .. 2**CYCLE_W-1");
  end

  localparam logic [CYCLE_W-1:0] MAX_C = CYCLE_W'(MAX_CYCLE);

  // Opcode class codes
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_CALL = 8'h01;
  localparam logic [7:0] OP_RET  = 8'h02;
  localparam logic [7:0] OP_OUT  = 8'h03;
  localparam logic [7:0] OP_IN   = 8'h04;
  localparam logic [7:0] OP_HLT  = 8'h05;
  localparam logic [7:0] OP_CMP  = 8'h06;
  localparam logic [7:0] OP_LDI  = 8'h10;
  localparam logic [7:0] OP_JMP  = 8'h18;
  localparam logic [7:0] OP_PUSH = 8'h20;
  localparam logic [7:0] OP_POP  = 8'h28;
  localparam logic [7:0] OP_ALU  = 8'h40;
  localparam logic [7:0] OP_MOV  = 8'h80;

  typedef enum logic [7:0] {
    S_NEXT       = 8'h00,
    S_FETCH_PC   = 8'h01,
    S_FETCH_INST = 8'h02,
    S_HALT       = 8'h03,
    S_JUMP       = 8'h04,
    S_OUT        = 8'h05,
    S_ALU_OUT    = 8'h06,
    S_ALU_EXEC   = 8'h07,
    S_MOV_STORE  = 8'h08,
    S_MOV_FETCH  = 8'h09,
    S_MOV_LOAD   = 8'h0A,
    S_FETCH_SP   = 8'h0C,
    S_PC_STORE   = 8'h0D,
    S_TMP_JUMP   = 8'h0E,
    S_RET        = 8'h0F,
    S_INC_SP     = 8'h10,
    S_SET_ADDR   = 8'h11,
    S_IN         = 8'h12,
    S_REG_STORE  = 8'h13,
    S_SET_REG    = 8'h14
  } ctrl_state_e;

  ctrl_state_e          state_q, state_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic                 inst_done_q, inst_done_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;

  logic [7:0]           op;
  logic                 op_defined;
  ctrl_state_e          step_s;

  // Upper instruction bits belong to the datapath; fold them so they are visibly consumed
  logic unused_inst_bits;
  assign unused_inst_bits = ^instruction;

  // Control state produced by one micro-cycle of a given opcode class
  function automatic ctrl_state_e step_f(input logic [CYCLE_W-1:0] c, input logic [7:0] o);
    ctrl_state_e s;
    s = S_NEXT;
    if (c == CYCLE_W'(0)) begin
      s = S_FETCH_PC;
    end else if (c == CYCLE_W'(1)) begin
      s = S_FETCH_INST;
    end else if (c == CYCLE_W'(2)) begin
      case (o)
        OP_HLT:                               s = S_HALT;
        OP_MOV:                               s = S_MOV_FETCH;
        OP_ALU, OP_CMP:                       s = S_ALU_EXEC;
        OP_RET, OP_POP:                       s = S_INC_SP;
        OP_PUSH:                              s = S_FETCH_SP;
        OP_IN, OP_OUT, OP_CALL, OP_LDI, OP_JMP: s = S_FETCH_PC;
        default:                              s = S_NEXT;
      endcase
    end else if (c == CYCLE_W'(3)) begin
      case (o)
        OP_JMP:          s = S_JUMP;
        OP_LDI, OP_CALL: s = S_SET_REG;
        OP_MOV:          s = S_MOV_LOAD;
        OP_ALU:          s = S_ALU_OUT;
        OP_OUT, OP_IN:   s = S_SET_ADDR;
        OP_PUSH:         s = S_REG_STORE;
        OP_RET, OP_POP:  s = S_FETCH_SP;
        default:         s = S_NEXT;
      endcase
    end else if (c == CYCLE_W'(4)) begin
      case (o)
        OP_MOV:  s = S_MOV_STORE;
        OP_CALL: s = S_FETCH_SP;
        OP_RET:  s = S_RET;
        OP_OUT:  s = S_OUT;
        OP_POP:  s = S_SET_REG;
        OP_IN:   s = S_IN;
        default: s = S_NEXT;
      endcase
    end else if (c == CYCLE_W'(5)) begin
      s = (o == OP_CALL) ? S_PC_STORE : S_NEXT;
    end else if (c == CYCLE_W'(6)) begin
      s = (o == OP_CALL) ? S_TMP_JUMP : S_NEXT;
    end
    return s;
  endfunction

  // Instruction byte to opcode class; unmatched bytes pass through unchanged
  always_comb begin
    op = instruction[7:0];
    casez (instruction[7:0])
      8'b00_010_???: op = OP_LDI;
      8'b10_???_???: op = OP_MOV;
      8'b01_???_000: op = OP_ALU;
      8'b00_011_???: op = OP_JMP;
      8'b00_100_???: op = OP_PUSH;
      8'b00_101_???: op = OP_POP;
      default:       op = instruction[7:0];
    endcase
  end

  // Flag opcode classes that have a defined micro-sequence
  always_comb begin
    op_defined = 1'b0;
    case (op)
      OP_NOP, OP_CALL, OP_RET, OP_OUT, OP_IN, OP_HLT, OP_CMP,
      OP_LDI, OP_JMP, OP_PUSH, OP_POP, OP_ALU, OP_MOV: op_defined = 1'b1;
      default:                                         op_defined = 1'b0;
    endcase
  end

  assign step_s = step_f(cycle_q, op);

  // Next-state selection: halt handshake, then stall freeze, then a normal step
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    halted_d    = halted_q;
    inst_done_d = 1'b0;
    illegal_d   = 1'b0;
    if (halted_q) begin
      if (run && !stall) begin
        state_d  = S_NEXT;
        halted_d = 1'b0;
      end
    end else if (!stall) begin
      state_d = step_s;
      if (step_s == S_HALT) begin
        cycle_d  = '0;
        halted_d = 1'b1;
      end else if (step_s == S_NEXT || cycle_q == MAX_C) begin
        // A sequence running into MAX_CYCLE is cut short and retired
        state_d     = S_NEXT;
        cycle_d     = '0;
        inst_done_d = 1'b1;
      end else begin
        cycle_d = cycle_q + CYCLE_W'(1);
      end
      if (cycle_q == CYCLE_W'(2) && !op_defined) begin
        illegal_d = 1'b1;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        state_d     = S_HALT;
        cycle_d     = '0;
        halted_d    = 1'b1;
        inst_done_d = 1'b0;
`endif
      end
    end
  end

  // Registered sequencer state and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_NEXT;
      cycle_q     <= '0;
      inst_done_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      inst_done_q <= inst_done_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  assign state     = state_q;
  assign cycle     = cycle_q;
  assign opcode    = op;
  assign inst_done = inst_done_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - randomized self-checking bench for cpu_ctrl_seq
module tb_cpu_ctrl_seq;

  localparam int INST_W  = 8;
  localparam int CYCLE_W = 4;
  localparam int MAXC    = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic [INST_W-1:0]  instruction;
  logic               stall;
  logic               run;
  logic [7:0]         state;
  logic [CYCLE_W-1:0] cycle;
  logic [7:0]         opcode;
  logic               inst_done;
  logic               halted;
  logic               illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_seq[$];
  logic [7:0] picks [0:15] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h13,
                               8'h82, 8'h48, 8'h1C, 8'h25, 8'h2F, 8'h41, 8'hC3, 8'h0B};

  cpu_ctrl_seq #(.INST_W(INST_W), .CYCLE_W(CYCLE_W), .MAX_CYCLE(MAXC)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .stall(stall), .run(run),
    .state(state), .cycle(cycle), .opcode(opcode), .inst_done(inst_done),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] s, input int c,
                           input bit d, input bit h, input bit il);
    check_eq({tag, ".state"}, state, s);
    check_eq({tag, ".cycle"}, cycle, c);
    check_eq({tag, ".inst_done"}, inst_done, d);
    check_eq({tag, ".halted"}, halted, h);
    check_eq({tag, ".illegal"}, illegal, il);
  endtask

  // Opcode class from the instruction byte, using field arithmetic
  function automatic logic [7:0] model_decode(input logic [7:0] b);
    int hi, mid, lo;
    hi  = int'(b) / 64;
    mid = (int'(b) / 8) % 8;
    lo  = int'(b) % 8;
    if (hi == 0 && mid == 2) return 8'h10;
    if (hi == 2)             return 8'h80;
    if (hi == 1 && lo == 0)  return 8'h40;
    if (hi == 0 && mid == 3) return 8'h18;
    if (hi == 0 && mid == 4) return 8'h20;
    if (hi == 0 && mid == 5) return 8'h28;
    return b;
  endfunction

  function automatic bit model_defined(input logic [7:0] o);
    return (o <= 8'h06) || o == 8'h10 || o == 8'h18 || o == 8'h20 ||
           o == 8'h28 || o == 8'h40 || o == 8'h80;
  endfunction

  // Whole control-state listing of an instruction, before the retiring NEXT
  function automatic void build_seq(input logic [7:0] o);
    exp_seq = {8'h01, 8'h02};
    case (o)
      8'h05: exp_seq.push_back(8'h03);
      8'h80: exp_seq = {exp_seq, 8'h09, 8'h0A, 8'h08};
      8'h40: exp_seq = {exp_seq, 8'h07, 8'h06};
      8'h06: exp_seq = {exp_seq, 8'h07};
      8'h02: exp_seq = {exp_seq, 8'h10, 8'h0C, 8'h0F};
      8'h28: exp_seq = {exp_seq, 8'h10, 8'h0C, 8'h14};
      8'h20: exp_seq = {exp_seq, 8'h0C, 8'h13};
      8'h04: exp_seq = {exp_seq, 8'h01, 8'h11, 8'h12};
      8'h03: exp_seq = {exp_seq, 8'h01, 8'h11, 8'h05};
      8'h01: exp_seq = {exp_seq, 8'h01, 8'h14, 8'h0C, 8'h0D, 8'h0E};
      8'h10: exp_seq = {exp_seq, 8'h01, 8'h14};
      8'h18: exp_seq = {exp_seq, 8'h01, 8'h04};
      default: ;
    endcase
  endfunction

  // Drive one instruction to completion and compare every clock with the listing
  task automatic run_instr(input logic [7:0] ins, input int stall_at, input bit rnd,
                           input int reset_at, input int hold_n);
    logic [7:0] opc;
    logic [7:0] prev_s;
    bit legal, halt_case, do_stall, last;
    int n_exp, idx, stalls, consec, prev_c, exp_c, rst_at;
    instruction = ins;
    opc   = model_decode(ins);
    legal = model_defined(opc);
    build_seq(opc);
    halt_case = (opc == 8'h05);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    if (!legal) begin
      halt_case = 1'b1;
      exp_seq.push_back(8'h03);
    end
`endif
    if (!halt_case) begin
      while (exp_seq.size() > MAXC) void'(exp_seq.pop_back());
      exp_seq.push_back(8'h00);
    end
    n_exp  = exp_seq.size();
    idx    = 0;
    stalls = 0;
    consec = 0;
    prev_s = 8'h00;
    prev_c = 0;
    rst_at = reset_at;
    while (idx < n_exp) begin
      if (idx == rst_at) begin
        reset = 1'b1;
        stall = 1'b0;
        step();
        check_all("reset_mid", 8'h00, 0, 1'b0, 1'b0, 1'b0);
        reset  = 1'b0;
        rst_at = -1;
        idx    = 0;
        prev_s = 8'h00;
        prev_c = 0;
        continue;
      end
      do_stall = 1'b0;
      if (idx == stall_at && stalls < 3) begin
        do_stall = 1'b1;
        stalls++;
      end else if (rnd && consec < 3 && $urandom_range(0, 3) == 0) begin
        do_stall = 1'b1;
      end
      stall = do_stall;
      step();
      check_eq("opcode", opcode, opc);
      if (do_stall) begin
        consec++;
        check_all("stall_hold", prev_s, prev_c, 1'b0, 1'b0, 1'b0);
      end else begin
        consec = 0;
        last   = (idx == n_exp - 1);
        exp_c  = last ? 0 : idx + 1;
        check_all("step", exp_seq[idx], exp_c, last && !halt_case, last && halt_case,
                  (idx == 2) && !legal);
        prev_s = exp_seq[idx];
        prev_c = exp_c;
        idx++;
      end
    end
    stall = 1'b0;
    if (halt_case) begin
      run = 1'b0;
      for (int i = 0; i < hold_n; i++) begin
        stall = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        check_all("halt_hold", 8'h03, 0, 1'b0, 1'b1, 1'b0);
      end
      run   = 1'b1;
      stall = 1'b1;
      step();
      check_all("halt_run_stalled", 8'h03, 0, 1'b0, 1'b1, 1'b0);
      stall = 1'b0;
      step();
      check_all("halt_resume", 8'h00, 0, 1'b0, 1'b0, 1'b0);
      run = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] b;
    reset       = 1'b1;
    instruction = '0;
    stall       = 1'b0;
    run         = 1'b0;
    step();
    step();
    check_all("reset", 8'h00, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    run_instr(8'h00, -1, 1'b0, -1, 0);
    run_instr(8'h00, -1, 1'b0, -1, 0);
    run_instr(8'h01, -1, 1'b0, -1, 0);
    run_instr(8'h05, -1, 1'b0, -1, 10);
    run_instr(8'h82, 3, 1'b0, -1, 0);
    run_instr(8'h41, -1, 1'b0, -1, 3);
    run_instr(8'h01, -1, 1'b0, 4, 0);
    run_instr(8'h05, 2, 1'b0, -1, 2);
    run_instr(8'hFF, -1, 1'b0, -1, 2);
    run_instr(8'h3F, -1, 1'b0, -1, 2);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 1) b = picks[$urandom_range(0, 15)];
      else                           b = 8'($urandom_range(0, 255));
      run_instr(b, -1, 1'b1, -1, $urandom_range(1, 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
